// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone round-robin arbiter with a CYC-long grant.
// Slave RTY and an ACK watchdog end a burst early so no master can hog the bus.
module wb_rr_arbiter #(
    parameter int NUM_M   = 2,
    parameter int DW      = 128,
    parameter int AW      = 12,
    parameter int SELW    = DW / 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_M-1:0]      m_cyc,
    input  logic [NUM_M-1:0]      m_stb,
    input  logic [NUM_M-1:0]      m_we,
    input  logic [NUM_M*AW-1:0]   m_adr,
    input  logic [NUM_M*SELW-1:0] m_sel,
    input  logic [NUM_M*DW-1:0]   m_dat_m,
    output logic [DW-1:0]         m_dat_s,
    output logic [NUM_M-1:0]      m_ack,
    output logic [NUM_M-1:0]      m_rty,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [AW-1:0]         s_adr,
    output logic [SELW-1:0]       s_sel,
    output logic [DW-1:0]         s_dat_m,
    input  logic [DW-1:0]         s_dat_s,
    input  logic                  s_ack,
    input  logic                  s_rty,
    output logic [NUM_M-1:0]      grant
);

    localparam int IW = $clog2(NUM_M);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IW-1:0]    g_q, g_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]    wdog_q, wdog_d;

    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          cyc_g;
    logic          stb_g;
    logic          stall;
    logic          fire;

    assign m_dat_s = s_dat_s;
    assign grant   = grant_q;

    // First requester at or after rr_ptr, wrapping modulo NUM_M
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % NUM_M);
            if (!found && m_cyc[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign cyc_g = m_cyc[g_q];
    assign stb_g = cyc_g & m_stb[g_q];
    assign stall = stb_g & ~s_ack & ~s_rty;
    assign fire  = stall && (wdog_q == WW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_m  = '0;
        m_ack    = '0;
        m_rty    = '0;
        unique case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    g_d           = pick;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                s_cyc        = cyc_g & ~fire;
                s_stb        = stb_g & ~fire;
                s_we         = m_we[g_q];
                s_adr        = m_adr[g_q*AW +: AW];
                s_sel        = m_sel[g_q*SELW +: SELW];
                s_dat_m      = m_dat_m[g_q*DW +: DW];
                m_ack[g_q]   = s_ack;
                // ACK wins over a simultaneous RTY
                m_rty[g_q]   = (s_rty & ~s_ack) | fire;
                wdog_d       = stall ? wdog_q + WW'(1) : '0;
                if (!cyc_g || (s_rty && !s_ack) || fire) begin
                    state_d  = RELEASE;
                    wdog_d   = '0;
                    grant_d  = '0;
                    rr_ptr_d = (g_q == IW'(NUM_M - 1)) ? '0 : g_q + IW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            g_q      <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, 32-bit data, TIMEOUT=8.
// Inputs change 1ns after each rising edge; outputs are sampled 3ns later.
module tb_wb_rr_arbiter;

    localparam int NUM_M = 2;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int SELW  = 4;

    logic                  CLK;
    logic                  RST_N;
    logic [NUM_M-1:0]      m_cyc;
    logic [NUM_M-1:0]      m_stb;
    logic [NUM_M-1:0]      m_we;
    logic [NUM_M*AW-1:0]   m_adr;
    logic [NUM_M*SELW-1:0] m_sel;
    logic [NUM_M*DW-1:0]   m_dat_m;
    logic [DW-1:0]         m_dat_s;
    logic [NUM_M-1:0]      m_ack;
    logic [NUM_M-1:0]      m_rty;
    logic                  s_cyc;
    logic                  s_stb;
    logic                  s_we;
    logic [AW-1:0]         s_adr;
    logic [SELW-1:0]       s_sel;
    logic [DW-1:0]         s_dat_m;
    logic [DW-1:0]         s_dat_s;
    logic                  s_ack;
    logic                  s_rty;
    logic [NUM_M-1:0]      grant;

    int n_chk;
    int n_err;
    int acks;

    wb_rr_arbiter #(
        .NUM_M  (NUM_M),
        .DW     (DW),
        .AW     (AW),
        .SELW   (SELW),
        .TIMEOUT(8)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_we   (m_we),
        .m_adr  (m_adr),
        .m_sel  (m_sel),
        .m_dat_m(m_dat_m),
        .m_dat_s(m_dat_s),
        .m_ack  (m_ack),
        .m_rty  (m_rty),
        .s_cyc  (s_cyc),
        .s_stb  (s_stb),
        .s_we   (s_we),
        .s_adr  (s_adr),
        .s_sel  (s_sel),
        .s_dat_m(s_dat_m),
        .s_dat_s(s_dat_s),
        .s_ack  (s_ack),
        .s_rty  (s_rty),
        .grant  (grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic zero_inputs();
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_sel   = '0;
        m_dat_m = '0;
        s_ack   = 1'b0;
        s_rty   = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        zero_inputs();
        nxt();
        nxt();
        RST_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        n_chk   = 0;
        n_err   = 0;
        acks    = 0;
        RST_N   = 1'b0;
        s_dat_s = 32'hCAFE_0001;
        zero_inputs();
        #2;
        check("rst_grant", grant, 0);
        check("rst_scyc", s_cyc, 0);
        check("rst_sstb", s_stb, 0);
        check("rst_ack", m_ack, 0);
        check("rst_rty", m_rty, 0);
        check("rst_dat", m_dat_s, 32'hCAFE_0001);
        nxt();
        RST_N = 1'b1;

        // single master, 4-beat read
        nxt();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_adr = 24'h000_100;
        m_sel = 8'h0F;
        #3;
        check("t1_idle_grant", grant, 0);
        check("t1_idle_scyc", s_cyc, 0);
        for (int b = 0; b < 4; b++) begin
            nxt();
            s_ack = 1'b1;
            #3;
            if (b == 0) begin
                check("t1_scyc", s_cyc, 1);
                check("t1_grant", grant, 2'b01);
                check("t1_adr", s_adr, 12'h100);
                check("t1_sel", s_sel, 4'hF);
                check("t1_ack1", m_ack[1], 0);
            end
            acks += int'(m_ack[0]);
        end
        check("t1_acks", acks, 4);
        nxt();
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        #3;
        check("t1_drop_scyc", s_cyc, 0);
        nxt();
        #3;
        check("t1_rel_grant", grant, 0);

        // contention from reset, then alternation
        do_reset();
        nxt();
        m_cyc   = 2'b11;
        m_stb   = 2'b11;
        m_adr   = {12'h300, 12'h200};
        m_dat_m = {32'h2222_2222, 32'h1111_1111};
        #3;
        check("t2_idle", grant, 0);
        nxt();
        s_ack = 1'b1;
        #3;
        check("t2_g0", grant, 2'b01);
        check("t2_ack0", m_ack, 2'b01);
        check("t2_adr0", s_adr, 12'h200);
        nxt();
        s_ack = 1'b0;
        m_cyc = 2'b10;
        m_stb = 2'b10;
        #3;
        check("t2_drop", s_cyc, 0);
        nxt();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        #3;
        check("t2_rel_grant", grant, 0);
        check("t2_rel_scyc", s_cyc, 0);
        nxt();
        #3;
        check("t2_arb_grant", grant, 0);
        nxt();
        s_ack = 1'b1;
        #3;
        check("t2_g1", grant, 2'b10);
        check("t2_ack1", m_ack, 2'b10);
        check("t2_adr1", s_adr, 12'h300);
        check("t2_dat1", s_dat_m, 32'h2222_2222);
        nxt();
        s_ack = 1'b0;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        #3;
        check("t2_drop1", s_cyc, 0);
        nxt();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        #3;
        nxt();
        #3;
        nxt();
        s_ack = 1'b1;
        #3;
        check("t2_alt", grant, 2'b01);

        // slave RTY on beat 2 of master 1 while master 0 waits
        nxt();
        s_ack = 1'b0;
        m_cyc = 2'b10;
        m_stb = 2'b10;
        #3;
        nxt();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        #3;
        nxt();
        #3;
        nxt();
        s_ack = 1'b1;
        #3;
        check("t3_beat1", m_ack, 2'b10);
        nxt();
        s_ack = 1'b0;
        s_rty = 1'b1;
        #3;
        check("t3_rty", m_rty, 2'b10);
        check("t3_noack", m_ack, 0);
        nxt();
        s_rty = 1'b0;
        #3;
        check("t3_rel_grant", grant, 0);
        check("t3_rel_rty", m_rty, 0);
        nxt();
        #3;
        nxt();
        // ACK and RTY together: ACK wins, grant kept
        s_ack = 1'b1;
        s_rty = 1'b1;
        #3;
        check("t3_g0", grant, 2'b01);
        check("t5_ack", m_ack, 2'b01);
        check("t5_rty", m_rty, 0);
        nxt();
        s_ack = 1'b0;
        s_rty = 1'b0;
        #3;
        check("t5_keep", grant, 2'b01);
        check("t5_scyc", s_cyc, 1);
        nxt();
        m_cyc = '0;
        m_stb = '0;
        #3;
        nxt();
        #3;

        // watchdog: RTY on the 8th stalled STB cycle, twice in a row
        nxt();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        #3;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                nxt();
                #3;
                if (k < 7) begin
                    check("wd_wait", {m_rty, s_stb}, 3'b001);
                end else begin
                    check("wd_fire", m_rty, 2'b01);
                    check("wd_cyc", {s_cyc, s_stb}, 0);
                end
            end
            nxt();
            if (r == 1) begin
                m_cyc = '0;
                m_stb = '0;
            end
            #3;
            check("wd_rel", {grant, m_rty}, 0);
            nxt();
            #3;
        end

        // reset in the middle of a write burst
        nxt();
        m_cyc   = 2'b10;
        m_stb   = 2'b10;
        m_we    = 2'b10;
        m_adr   = {12'h3A5, 12'h000};
        m_dat_m = {32'hDEAD_BEEF, 32'h0};
        #3;
        nxt();
        s_ack = 1'b1;
        #3;
        check("t6_we", s_we, 1);
        check("t6_dat", s_dat_m, 32'hDEAD_BEEF);
        check("t6_ack", m_ack, 2'b10);
        nxt();
        #3;
        check("t6_beat2", m_ack, 2'b10);
        #1;
        RST_N = 1'b0;
        #1;
        check("t6_rst_cyc", {s_cyc, s_stb}, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_ack", m_ack, 0);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = '0;
        s_ack = 1'b0;
        nxt();
        RST_N = 1'b1;
        #3;
        check("t6_idle", grant, 0);
        nxt();
        #3;
        check("t6_restart", grant, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
